// File: rtl/fetch_pkg.sv
// Shared fetch types: instruction/pair widths and the decode-queue entry.
package fetch_pkg;

    localparam int INST_W = 32;
    localparam int PAIR_W = 64;
    localparam int PC_W   = 32;

    localparam logic [INST_W-1:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst_2;
        logic [INST_W-1:0] inst_1;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    function automatic logic [PC_W-1:0] pair_addr(input logic [PC_W-1:0] a);
        return {a[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear; head is read combinationally.
module sync_fifo #(
    parameter int W = 8,
    parameter int D = 4,
    localparam int AW = (D > 1) ? $clog2(D) : 1,
    localparam int CW = $clog2(D) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    logic [W-1:0]  mem [D];
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(D - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(D));
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            for (int i = 0; i < D; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= next_ptr(wptr);
            end
            if (do_pop) begin
                rptr <= next_ptr(rptr);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_pair_queue.sv
// Fetch back end: credit-limited pair reads, redirect drop tracking,
// and a registered decode queue.
module fetch_pair_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   pc,
    input  logic              flush,
    output logic              pc_hold,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [PAIR_W-1:0] imem_rdata,
    output logic              de_valid,
    output logic [PC_W-1:0]   de_pc,
    output logic [INST_W-1:0] de_inst_1,
    output logic [INST_W-1:0] de_inst_2,
    input  logic              de_ready
);

    localparam int QCW = $clog2(DEPTH) + 1;
    localparam int OCW = $clog2(MAX_OUT) + 1;
    localparam int TCW = $clog2(MAX_OUT) + 1;
    localparam int SW  = ((QCW > OCW) ? QCW : OCW) + 1;

    logic [OCW-1:0] out_cnt;
    logic [OCW-1:0] drop_cnt;

    logic [PC_W-1:0] tag_pc;
    logic [TCW-1:0]  tag_count;
    logic            tag_empty;
    logic            tag_full;

    fetch_entry_t    q_din;
    fetch_entry_t    q_head;
    logic [QCW-1:0]  q_count;
    logic            q_empty;
    logic            q_full;

    logic [SW-1:0]   pending;
    logic            credit;
    logic            grant;
    logic            rsp;
    logic            dropping;
    logic            q_push;
    logic            q_pop;

    // Slots already promised to the queue include every in-flight read.
    assign pending  = SW'(out_cnt) + SW'(q_count);
    assign credit   = (out_cnt < OCW'(MAX_OUT)) && (pending < SW'(DEPTH));
    assign imem_req = !rst && !flush && credit;
    assign grant    = imem_req && imem_gnt;
    assign pc_hold  = !rst && !flush && !grant;

    assign imem_addr = pair_addr(pc);

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp      = imem_rvalid && (out_cnt != '0);
    assign dropping = (drop_cnt != '0);
    assign q_push   = rsp && !dropping;
    assign q_pop    = de_valid && de_ready;

    assign q_din = '{pc: tag_pc,
                     inst_2: imem_rdata[63:32],
                     inst_1: imem_rdata[31:0]};

    sync_fifo #(
        .W (PC_W),
        .D (MAX_OUT)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .push  (grant),
        .pop   (rsp),
        .din   (pc),
        .dout  (tag_pc),
        .count (tag_count),
        .empty (tag_empty),
        .full  (tag_full)
    );

    sync_fifo #(
        .W (ENTRY_W),
        .D (DEPTH)
    ) u_data_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (q_push),
        .pop   (q_pop),
        .din   (q_din),
        .dout  (q_head),
        .count (q_count),
        .empty (q_empty),
        .full  (q_full)
    );

    assign de_valid  = !q_empty;
    assign de_pc     = q_head.pc;
    assign de_inst_1 = q_head.inst_1;
    assign de_inst_2 = q_head.inst_2;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            out_cnt <= out_cnt + OCW'(grant) - OCW'(rsp);
            if (flush) begin
                drop_cnt <= out_cnt - OCW'(rsp);
            end else if (rsp && dropping) begin
                drop_cnt <= drop_cnt - OCW'(1);
            end
        end
    end

    logic unused;
    assign unused = ^{tag_count, tag_empty, tag_full, q_full};

endmodule

// File: doc/fetch_pair_queue.md
# fetch_pair_queue

Instruction-fetch back end for the two-issue pipeline. It consumes the fetch PC from the PC register and issues pair-wide reads to instruction memory over a request/grant port. It tracks in-flight reads, discards responses made stale by a redirect, and buffers returned instruction pairs for the decode stage behind a valid/ready handshake. Back-pressure returns to the PC register as `pc_hold`.

## Interface
- `DEPTH`, default 4: decode-side queue entries; power of two, ≥2.
- `MAX_OUT`, default 2: maximum in-flight memory reads; power of two, ≥1, ≤`DEPTH`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `pc` in 32: current fetch PC from the PC register.
- `flush` in 1: redirect this cycle; the PC register loads the target and `pc` shows it next cycle.
- `pc_hold` out 1: PC register must keep `pc` (request not accepted).
- `imem_req` out 1: read request.
- `imem_addr` out 32: read address, `{pc[31:2],2'b00}`.
- `imem_gnt` in 1: request accepted when `imem_req & imem_gnt`.
- `imem_rvalid` in 1: one read response, in request order.
- `imem_rdata` in 64: `[31:0]` = word at addr, `[63:32]` = word at addr+4.
- `de_valid` out 1: queue head valid.
- `de_pc` out 32: PC of head pair.
- `de_inst_1` out 32: head word at `de_pc`.
- `de_inst_2` out 32: head word at `de_pc`+4.
- `de_ready` in 1: decode pops head when `de_valid & de_ready`.

## Operation
- State: `out_cnt` (in-flight reads, 0..`MAX_OUT`), `drop_cnt` (stale responses still to arrive), a tag FIFO of `MAX_OUT` PCs, and a data FIFO of `DEPTH` entries {pc, inst_2, inst_1}.
- Credit: `imem_req = !rst & !flush & (out_cnt < MAX_OUT) & (out_cnt + fifo_count < DEPTH)`. `out_cnt` counts all in-flight reads, including those marked for drop, so credit is conservative.
- Accept: `imem_req & imem_gnt` pushes `pc` to the tag FIFO and increments `out_cnt`.
- `pc_hold = !rst & !flush & !(imem_req & imem_gnt)`.
- Response: `imem_rvalid` pops the tag FIFO and decrements `out_cnt`.
  - If `drop_cnt > 0`, decrement `drop_cnt` and discard the data.
  - Otherwise push {tag, `imem_rdata[63:32]`, `imem_rdata[31:0]`} to the data FIFO.
- `imem_rvalid` with `out_cnt == 0` is a protocol error: ignore it and change no state.
- Flush:
  - Clear the data FIFO. A same-cycle pop is irrelevant and a same-cycle push is discarded.
  - Set `drop_cnt` to `out_cnt` minus 1 if `imem_rvalid` arrives that cycle, else `out_cnt`.
  - No request issues during a flush cycle.
  - The tag FIFO keeps its entries; stale tags are popped by the dropped responses.
- Decode outputs show the data-FIFO head. When the FIFO is empty, `de_pc`/`de_inst_*` hold the last value and carry no meaning.
- Simultaneous push and pop on the data FIFO is legal at any occupancy that credit allows. Credit makes overflow impossible.

## Timing
- Reset values: `imem_req`=0, `pc_hold`=0, `de_valid`=0, `de_pc`=0, `de_inst_1`=0, `de_inst_2`=0, `out_cnt`=0, `drop_cnt`=0, both FIFOs empty. Reset mid-transfer discards everything; memory must also be reset.
- Grant at cycle t, response at t+L (L≥1) → `de_valid` at t+L+1 (registered queue, no bypass).
- Back-to-back grants sustain one pair per cycle while credit remains and decode pops every cycle.
- The first post-flush request issues the cycle after the flush, using the target `pc`. Its response is the first one not dropped.
- Pop takes effect at the clock edge; the new head is visible the next cycle.

## Structure
- Shared package `fetch_pkg`: `INST_W`=32, `PAIR_W`=64, a fetch-entry struct/field widths {pc, inst_2, inst_1}, and the `NOP` constant 32'h0000_0000.
- One sub-module, `sync_fifo` (parameterised width/depth, push/pop/clear, count, empty/full). Instantiate it twice: tag FIFO and data FIFO.
- Counters and credit logic stay in the top module.

## Test plan
- Reset then `pc`=0x100, `imem_gnt`=1, L=1, `de_ready`=1 → grant cycle 1; `de_valid` cycle 3 with `de_pc`=0x100; steady one pair per cycle.
- `imem_gnt`=0 for 3 cycles → `pc_hold`=1 throughout, `imem_addr` stable at 0x100; no tag pushed.
- `de_ready`=0, L=1 → at most `DEPTH`=4 grants then `imem_req`=0; releasing `de_ready` drains 0x100..0x118 in order.
- Two reads in flight (L=3), `flush` with target 0x400 → both responses dropped, `drop_cnt` returns to 0, first `de_pc` after flush = 0x400.
- `flush` in the same cycle as `imem_rvalid` and as a decode pop, with one other read outstanding → `drop_cnt`=1, data FIFO empty next cycle, next accepted pair appears.
- `imem_rvalid` pulse with nothing outstanding → no `de_valid`, counters unchanged.
